// File: rtl/trig_generator_multi.sv
// trig_generator_multi: decodes register-bus writes into NUM_TRIG independent
// trigger pulses of PULSE_LEN cycles. Each channel queues one retrigger that
// arrives while it is busy and flags any further request as dropped.
module trig_generator_multi #(
  parameter int unsigned ADDR_W    = 11,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned NUM_TRIG  = 10,
  parameter int unsigned BASE_ADDR = 'h00C,
  parameter int unsigned PULSE_LEN = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W-1:0]   wdata,
  input  logic                xfc,
  output logic [NUM_TRIG-1:0] trig,
  output logic [NUM_TRIG-1:0] trig_busy,
  output logic [NUM_TRIG-1:0] trig_drop
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Counter counts remaining high cycles after the current one.
  localparam logic [7:0] CNT_LOAD = 8'(PULSE_LEN - 1);

  logic [NUM_TRIG-1:0] req;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_TRIG; gi++) begin : g_chan
      // Channel gi lives in register gi/DATA_W, bit gi%DATA_W.
      localparam logic [ADDR_W-1:0] REG_ADDR = ADDR_W'(BASE_ADDR + gi / DATA_W);
      localparam int unsigned       BIT_IDX  = gi % DATA_W;

      state_t     state_reg, state_next;
      logic [7:0] cnt_reg, cnt_next;
      logic       pend_reg, pend_next;
      logic       drop_reg, drop_next;

      // Write-1-to-trigger decode; zero bits and other addresses are ignored.
      assign req[gi] = xfc && (address == REG_ADDR) && wdata[BIT_IDX];

      // Channel state register; reset wins over a same-cycle write.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          state_reg <= IDLE;
          cnt_reg   <= 8'd0;
          pend_reg  <= 1'b0;
          drop_reg  <= 1'b0;
        end else begin
          state_reg <= state_next;
          cnt_reg   <= cnt_next;
          pend_reg  <= pend_next;
          drop_reg  <= drop_next;
        end
      end

      // Next-state logic: pulse, optional one-cycle gap, queued retrigger.
      always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        pend_next  = pend_reg;
        drop_next  = 1'b0;
        case (state_reg)
          IDLE: begin
            if (req[gi]) begin
              state_next = PULSE;
              cnt_next   = CNT_LOAD;
            end
          end
          PULSE: begin
            // A request on the final pulse edge still counts as in-pulse,
            // so the gap decision looks at the updated pending flag.
            if (req[gi]) begin
              if (pend_reg) begin
                drop_next = 1'b1;
              end else begin
                pend_next = 1'b1;
              end
            end
            if (cnt_reg == 8'd0) begin
              state_next = pend_next ? GAP : IDLE;
            end else begin
              cnt_next = cnt_reg - 8'd1;
            end
          end
          GAP: begin
            // Consume the queued request; a new one arriving now re-queues.
            pend_next  = req[gi];
            state_next = PULSE;
            cnt_next   = CNT_LOAD;
          end
          default: begin
            state_next = IDLE;
            cnt_next   = 8'd0;
            pend_next  = 1'b0;
          end
        endcase
      end

      assign trig[gi]      = (state_reg == PULSE);
      assign trig_busy[gi] = (state_reg != IDLE) || pend_reg;
      assign trig_drop[gi] = drop_reg;
    end
  endgenerate

endmodule

// File: tb/tb_trig_generator_multi.sv
// Directed testbench for trig_generator_multi (default parameters).
module tb_trig_generator_multi;

  localparam int NT   = 10;
  localparam int PL   = 3;
  localparam int BASE = 'h00C;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [10:0]   address;
  logic [7:0]    wdata;
  logic          xfc;
  logic [NT-1:0] trig;
  logic [NT-1:0] trig_busy;
  logic [NT-1:0] trig_drop;

  int checks = 0;
  int errors = 0;

  // Scoreboard model: phase 0 idle, 1..PL pulse cycle index, PL+1 gap.
  int            m_phase [NT];
  bit            m_pend  [NT];
  logic [NT-1:0] m_drop;
  int            run_len [NT];

  trig_generator_multi dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .address   (address),
    .wdata     (wdata),
    .xfc       (xfc),
    .trig      (trig),
    .trig_busy (trig_busy),
    .trig_drop (trig_drop)
  );

  always #5 clk = ~clk;

  // Apply bus inputs, let one rising edge pass, land 2 time units after it.
  task automatic tick(input logic [10:0] a, input logic [7:0] d, input logic x);
    address = a;
    wdata   = d;
    xfc     = x;
    @(posedge clk);
    #2;
  endtask

  function automatic logic [NT-1:0] calc_req(input logic [10:0] a, input logic [7:0] d,
                                             input logic x);
    logic [NT-1:0] r;
    r = '0;
    for (int c = 0; c < NT; c++)
      r[c] = x && (a == 11'(BASE + c / 8)) && d[c % 8];
    return r;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NT; c++) begin
      m_phase[c] = 0;
      m_pend[c]  = 1'b0;
      run_len[c] = 0;
    end
    m_drop = '0;
  endtask

  task automatic model_step(input logic [NT-1:0] r);
    m_drop = '0;
    for (int c = 0; c < NT; c++) begin
      if (m_phase[c] == 0) begin
        if (r[c]) m_phase[c] = 1;
      end else if (m_phase[c] <= PL) begin
        if (r[c]) begin
          if (m_pend[c]) m_drop[c] = 1'b1;
          else           m_pend[c] = 1'b1;
        end
        if (m_phase[c] == PL) m_phase[c] = m_pend[c] ? PL + 1 : 0;
        else                  m_phase[c] = m_phase[c] + 1;
      end else begin
        m_pend[c]  = r[c];
        m_phase[c] = 1;
      end
    end
  endtask

  function automatic logic [NT-1:0] model_trig();
    logic [NT-1:0] v;
    for (int c = 0; c < NT; c++) v[c] = (m_phase[c] >= 1) && (m_phase[c] <= PL);
    return v;
  endfunction

  function automatic logic [NT-1:0] model_busy();
    logic [NT-1:0] v;
    for (int c = 0; c < NT; c++) v[c] = (m_phase[c] != 0) || m_pend[c];
    return v;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(11'h00C, 8'hFF, 1'b1);
      checks++;
      if ((trig !== '0) || (trig_busy !== '0) || (trig_drop !== '0)) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d trig=%h busy=%h drop=%h required all 0",
                 i, trig, trig_busy, trig_drop);
      end
    end
    rst_n = 1'b1;
    tick(11'h00C, 8'hFF, 1'b1);
    checks++;
    if (trig !== 10'h0FF) begin
      errors++;
      $display("FAIL reset_first_pulse trig=%h required %h", trig, 10'h0FF);
    end
    for (int i = 0; i < 6; i++) tick(11'h000, 8'h00, 1'b0);
    checks++;
    if ((trig !== '0) || (trig_busy !== '0)) begin
      errors++;
      $display("FAIL reset_quiesce trig=%h busy=%h required 0", trig, trig_busy);
    end
    $display("reset: done checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_single();
    logic [3:0] exp_t;
    exp_t = 4'b0111;
    for (int s = 0; s < 4; s++) begin
      tick(11'h00C, 8'h01, (s == 0));
      checks++;
      if ((trig !== {9'd0, exp_t[s]}) || (trig_busy !== {9'd0, exp_t[s]})) begin
        errors++;
        $display("FAIL single cyc=N+%0d trig=%h busy=%h required %h", s + 1, trig,
                 trig_busy, {9'd0, exp_t[s]});
      end
    end
    $display("single: done checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_upper_mask();
    logic [3:0] exp_t;
    exp_t = 4'b0111;
    for (int s = 0; s < 4; s++) begin
      tick(11'h00D, 8'hFF, (s == 0));
      checks++;
      if (trig !== (exp_t[s] ? 10'h300 : 10'h000)) begin
        errors++;
        $display("FAIL upper cyc=N+%0d trig=%h required %h", s + 1, trig,
                 exp_t[s] ? 10'h300 : 10'h000);
      end
    end
    tick(11'h00E, 8'hFF, 1'b1);
    tick(11'h00B, 8'hFF, 1'b1);
    tick(11'h00C, 8'h00, 1'b1);
    for (int s = 0; s < 3; s++) begin
      checks++;
      if ((trig !== '0) || (trig_busy !== '0)) begin
        errors++;
        $display("FAIL out_of_range cyc=%0d trig=%h busy=%h required 0", s, trig, trig_busy);
      end
      tick(11'h000, 8'h00, 1'b0);
    end
    $display("upper_mask: done checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_retrigger();
    logic [7:0] exp_t, exp_b, exp_d;
    exp_t = 8'b0111_0111;
    exp_b = 8'b0111_1111;
    exp_d = 8'b0000_0100;
    for (int s = 0; s < 8; s++) begin
      tick(11'h00C, 8'h01, (s < 3));
      checks++;
      if ((trig !== {9'd0, exp_t[s]}) || (trig_busy !== {9'd0, exp_b[s]}) ||
          (trig_drop !== {9'd0, exp_d[s]})) begin
        errors++;
        $display("FAIL retrigger cyc=N+%0d trig=%h busy=%h drop=%h required %h %h %h",
                 s + 1, trig, trig_busy, trig_drop, {9'd0, exp_t[s]}, {9'd0, exp_b[s]},
                 {9'd0, exp_d[s]});
      end
    end
    $display("retrigger: done checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_continuous();
    logic [10:0]   a;
    logic [7:0]    d;
    logic          x;
    int            drops_dut;
    int            drops_mod;
    int            max_run;
    logic [NT-1:0] et, eb;
    drops_dut = 0;
    drops_mod = 0;
    model_reset();
    for (int k = 0; k < 44; k++) begin
      a = 11'h00C;
      d = k[7:0];
      x = (k < 32);
      model_step(calc_req(a, d, x));
      tick(a, d, x);
      et = model_trig();
      eb = model_busy();
      checks++;
      if ((trig !== et) || (trig_busy !== eb) || (trig_drop !== m_drop)) begin
        errors++;
        $display("FAIL continuous k=%0d trig=%h busy=%h drop=%h required %h %h %h",
                 k, trig, trig_busy, trig_drop, et, eb, m_drop);
      end
      drops_dut += $countones(trig_drop);
      drops_mod += $countones(m_drop);
      max_run = 0;
      for (int c = 0; c < NT; c++) begin
        run_len[c] = trig[c] ? run_len[c] + 1 : 0;
        if (run_len[c] > max_run) max_run = run_len[c];
      end
      checks++;
      if (max_run > PL) begin
        errors++;
        $display("FAIL pulse_len k=%0d run=%0d required <= %0d", k, max_run, PL);
      end
    end
    checks++;
    if (drops_dut != drops_mod) begin
      errors++;
      $display("FAIL drop_count got=%0d required %0d", drops_dut, drops_mod);
    end
    $display("continuous: drops=%0d checks=%0d errors=%0d", drops_dut, checks, errors);
  endtask

  task automatic test_reset_mid_pulse();
    tick(11'h00C, 8'h01, 1'b1);
    tick(11'h00C, 8'h01, 1'b1);
    checks++;
    if ((trig[0] !== 1'b1) || (trig_busy[0] !== 1'b1)) begin
      errors++;
      $display("FAIL mid_pre trig0=%b busy0=%b required 1 1", trig[0], trig_busy[0]);
    end
    rst_n = 1'b0;
    tick(11'h000, 8'h00, 1'b0);
    rst_n = 1'b1;
    checks++;
    if ((trig !== '0) || (trig_busy !== '0) || (trig_drop !== '0)) begin
      errors++;
      $display("FAIL mid_reset trig=%h busy=%h drop=%h required 0", trig, trig_busy, trig_drop);
    end
    for (int s = 0; s < 6; s++) begin
      tick(11'h000, 8'h00, 1'b0);
      checks++;
      if ((trig !== '0) || (trig_busy !== '0)) begin
        errors++;
        $display("FAIL mid_after cyc=%0d trig=%h busy=%h required 0", s, trig, trig_busy);
      end
    end
    $display("reset_mid_pulse: done checks=%0d errors=%0d", checks, errors);
  endtask

  initial begin
    rst_n   = 1'b0;
    address = 11'h000;
    wdata   = 8'h00;
    xfc     = 1'b0;
    test_reset();
    test_single();
    test_upper_mask();
    test_retrigger();
    test_continuous();
    test_reset_mid_pulse();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
